lattice_scan_arbiter: RTL and testbench
=======================================

Name: lattice_scan_arbiter

Overview:
Shares one 8x8 dot-matrix display between two frame sources (requester 0 and requester 1) and drives the row/column scan.
- Latches a 64-bit frame only at frame boundaries, so the display never shows a half-updated (torn) image.
- Arbitrates round-robin with a minimum dwell time in frames.
- Advances one row per `scan_tick`. `scan_tick` comes from the existing frequency divider at about 500 Hz × 8 rows.
- Sits between glyph/pattern generators and the matrix pins.

Parameters:
- `DWELL`, default 4: minimum number of whole frames an owner keeps the display before the arbiter re-evaluates (range 1–255).
- `BLANK_IDLE`, default 1: when 1, the display shows all-zero columns if no requester is active; when 0, the last frame is held.

Ports:
- `clk` input 1: system clock (50 MHz).
- `rst` input 1: synchronous, active-high reset.
- `scan_tick` input 1: one-`clk` enable pulse; advances the scan by one row.
- `req` input 2: `req[i]` high = requester i wants the display; level, held while wanted.
- `frame0` input 64: requester 0 image; bits [8r+7:8r] = columns of row r.
- `frame1` input 64: requester 1 image, same layout.
- `gnt` output 2: one-`clk` pulse when requester i is newly given the display.
- `owner` output 2: one-hot current owner; 2'b00 = none.
- `frame_done` output 1: one-`clk` pulse coincident with each frame-boundary tick (`scan_tick` while `row_idx`==7).
- `row` output 8: active-low row select (bit r low = row r on).
- `col` output 8: column data for the selected row (1 = LED on).

Behaviour:
- Reset values (`rst` sampled on the `clk` edge):
  - `row`=8'hFF, `col`=8'h00, `gnt`=0, `owner`=0, `frame_done`=0.
  - Internal: `row_idx`=0, `frame_buf`=0, `dwell_cnt`=0, `last`=1, so requester 0 wins the first contended arbitration.
  - Reset asserted mid-frame aborts the scan immediately; the next scan starts at row 0.
- Scan, on each `clk` with `scan_tick`=1:
  - `row` <= ~(8'b1 << `row_idx`).
  - `col` <= `frame_buf`[8·`row_idx` +: 8].
  - `row_idx` <= `row_idx`+1, mod 8.
- With no `scan_tick`, all outputs hold except the `gnt`/`frame_done` pulses, which return to 0.
- Frame boundary, on a `scan_tick` with `row_idx`==7, all of the following in the same `clk`:
  - Row 7 of the old frame is presented and `frame_done`=1.
  - The state machine below evaluates, and `frame_buf` loads its result.
  - The next tick shows row 0 of the new content.
- States (evaluated only at a frame boundary):
  - IDLE (`owner`=0):
    - If any `req` is set, arbitrate (see below) → SHOW.
    - Otherwise stay. `frame_buf` <= 0 if `BLANK_IDLE`, else unchanged.
  - SHOW (owner k):
    - If `req[k]`=1 and `dwell_cnt` < `DWELL`-1: `dwell_cnt`++ and `frame_buf` <= `frame`k (live refresh, no `gnt`).
    - Otherwise arbitrate (see below).
- Arbitration:
  - Candidate order is round-robin starting after `last`.
  - The winner j gets `frame_buf` <= `frame`j, `owner`=j, `last`=j, `dwell_cnt`=0, and `gnt[j]`=1 for one `clk`.
  - If the winner equals the current owner (the other side is idle), this is a re-grant: `gnt` pulses again and `dwell_cnt` resets.
  - If no request is set → IDLE.
- `req` or frame changes between boundaries have no visible effect until the next boundary.
- A requester dropping `req` mid-frame keeps the display until that boundary.
- If `req` rises and falls between boundaries, it is never seen.
- Latency:
  - `req` assertion to `gnt`: ≤ 8·`DWELL` ticks when contended.
  - `req` assertion to `gnt`: ≤ 8 ticks when the display is idle or the owner has no contender at its next dwell expiry.
- `scan_tick` asserted while `rst`=1 is ignored.

Decomposition:
- Shared package `lattice_pkg`:
  - `ROWS`=8, `COLS`=8, `FRAME_W`=64.
  - Owner encoding constants `OWN_NONE`, `OWN_0`, `OWN_1`.
  - `ROW_OFF`=8'hFF.
- One natural sub-module: `lattice_row_scanner`. It holds `row_idx`, the `row`/`col` registers and `frame_done`, and takes `frame_buf` as input.
- The arbiter FSM and dwell counter stay in the top module.

Test Plan:
- Reset with `scan_tick` running → `row`=FF, `col`=00, `owner`=00 until the first post-reset tick; first tick gives `row`=FE.
- `req`=01, `frame0`=64'h0102040810204080 → `gnt[0]` pulse at the first boundary. Subsequent ticks give `row`=FE/`col`=80, then `row`=FD/`col`=40, …, then `row`=7F/`col`=01. `frame_done` pulses every 8th tick.
- `req`=11, `DWELL`=4 → owner sequence 0,0,0,0,1,1,1,1,0… per frame. Each `gnt` is exactly one `clk` wide, and pulses occur 32 ticks apart.
- `frame0` changed at mid-frame row 3 → rows 4–7 of the current frame keep the old data; the new data appears from row 0 of the next frame (no tearing).
- Owner 0 drops `req` at row 5 with `req[1]`=0, `BLANK_IDLE`=1 → `owner`=00 at the boundary, and `col`=00 for all rows of the next frame.
- `rst` pulsed at `row_idx`=5 while `owner`=1 → `row`=FF, `owner`=00. After release with `req`=11, requester 0 is granted first.

Source files
------------

// File: rtl/lattice_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lattice_pkg
//  Description : Shared constants and helpers for the 8x8 lattice display
//                arbiter: matrix geometry, one-hot owner codes, row-off value.
//  Revision    : 1.0 - initial release
// ============================================================================
package lattice_pkg;

    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int FRAME_W = 64;

    // One-hot owner codes as presented on the owner output.
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_0    = 2'b01;
    localparam logic [1:0] OWN_1    = 2'b10;

    // Active-low row drive with every row switched off.
    localparam logic [7:0] ROW_OFF  = 8'hFF;

    // Requester index to one-hot owner code.
    function automatic logic [1:0] own_onehot(input logic idx);
        return idx ? OWN_1 : OWN_0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lattice_row_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : lattice_row_scanner
//  Description : Row/column scan engine. Each scan tick presents one row of
//                the latched frame and advances the row index; the tick on
//                the last row raises frame_done for one clk.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                i_scan_tick      - one-clk row advance enable
//                i_frame_buf      - latched 64-bit frame (8 bits per row)
//                o_row_idx        - row that the next tick will present
//                o_frame_done     - one-clk pulse on the frame-boundary tick
//                o_row / o_col    - active-low row select / column data
//  Revision    : 1.0 - initial release
// ============================================================================
module lattice_row_scanner
    import lattice_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_scan_tick,
    input  logic [FRAME_W-1:0] i_frame_buf,
    output logic [2:0]         o_row_idx,
    output logic               o_frame_done,
    output logic [ROWS-1:0]    o_row,
    output logic [COLS-1:0]    o_col
);

    logic [2:0]      r_row_idx;
    logic            r_frame_done;
    logic [ROWS-1:0] r_row;
    logic [COLS-1:0] r_col;
    logic [5:0]      w_bit_base;

    assign w_bit_base = {r_row_idx, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_idx    <= 3'd0;
            r_frame_done <= 1'b0;
            r_row        <= ROW_OFF;
            r_col        <= '0;
        end else if (i_scan_tick) begin
            r_row        <= ~(8'd1 << r_row_idx);
            r_col        <= i_frame_buf[w_bit_base +: COLS];
            r_row_idx    <= r_row_idx + 3'd1;     // wraps 7 -> 0
            r_frame_done <= (r_row_idx == 3'd7);
        end else begin
            r_frame_done <= 1'b0;
        end
    end

    assign o_row_idx    = r_row_idx;
    assign o_frame_done = r_frame_done;
    assign o_row        = r_row;
    assign o_col        = r_col;

endmodule
`default_nettype wire

// File: rtl/lattice_scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lattice_scan_arbiter
//  Description : Shares one 8x8 dot-matrix between two frame sources.
//                Ownership and the displayed frame change only at frame
//                boundaries (no tearing); round-robin arbitration with a
//                minimum dwell of DWELL frames per owner.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                scan_tick    - one-clk row advance enable
//                req[1:0]     - level requests from the two sources
//                frame0/1     - 64-bit images, bits [8r+7:8r] = row r
//                gnt[1:0]     - one-clk pulse on each (re)grant
//                owner[1:0]   - one-hot current owner, 00 = none
//                frame_done   - one-clk pulse on each frame-boundary tick
//                row / col    - active-low row select / column data
//  Revision    : 1.0 - initial release
// ============================================================================
module lattice_scan_arbiter
    import lattice_pkg::*;
#(
    parameter int DWELL      = 4,
    parameter bit BLANK_IDLE = 1'b1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_tick,
    input  logic [1:0]         req,
    input  logic [FRAME_W-1:0] frame0,
    input  logic [FRAME_W-1:0] frame1,
    output logic [1:0]         gnt,
    output logic [1:0]         owner,
    output logic               frame_done,
    output logic [ROWS-1:0]    row,
    output logic [COLS-1:0]    col
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SHOW = 1'b1;

    localparam logic [7:0] c_dwell_lim = 8'(DWELL - 1);

    logic [0:0]         r_state,     w_state_nxt;
    logic               r_owner_idx, w_owner_idx_nxt;
    logic [1:0]         r_owner,     w_owner_nxt;
    logic               r_last,      w_last_nxt;
    logic [7:0]         r_dwell,     w_dwell_nxt;
    logic [FRAME_W-1:0] r_frame_buf, w_frame_buf_nxt;
    logic [1:0]         r_gnt,       w_gnt_nxt;

    logic [2:0]         w_row_idx;
    logic               w_boundary;
    logic               w_keep;
    logic               w_first;
    logic               w_win_idx;
    logic               w_win_valid;

    lattice_row_scanner u_scanner (
        .clk          (clk),
        .rst          (rst),
        .i_scan_tick  (scan_tick),
        .i_frame_buf  (r_frame_buf),
        .o_row_idx    (w_row_idx),
        .o_frame_done (frame_done),
        .o_row        (row),
        .o_col        (col)
    );

    // The frame buffer is reloaded on the same edge that shows row 7, so
    // row 7 still comes from the old frame and row 0 from the new one.
    assign w_boundary = scan_tick && (w_row_idx == 3'd7);

    // Owner keeps the display while it still wants it and dwell remains.
    assign w_keep = (r_state == S_SHOW) && req[r_owner_idx] && (r_dwell < c_dwell_lim);

    // Round-robin: the side after the last winner is tried first.
    assign w_first     = ~r_last;
    assign w_win_valid = |req;
    assign w_win_idx   = req[w_first] ? w_first : r_last;

    // ---- state register ----------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- next-state logic --------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_boundary && !w_keep) begin
            w_state_nxt = w_win_valid ? S_SHOW : S_IDLE;
        end
    end

    // ---- output / datapath next values -------------------------------------
    always_comb begin
        w_owner_idx_nxt = r_owner_idx;
        w_owner_nxt     = r_owner;
        w_last_nxt      = r_last;
        w_dwell_nxt     = r_dwell;
        w_frame_buf_nxt = r_frame_buf;
        w_gnt_nxt       = 2'b00;
        if (w_boundary) begin
            if (w_keep) begin
                w_dwell_nxt     = r_dwell + 8'd1;
                w_frame_buf_nxt = r_owner_idx ? frame1 : frame0;
            end else if (w_win_valid) begin
                // Also covers a re-grant to the current owner.
                w_owner_idx_nxt = w_win_idx;
                w_owner_nxt     = own_onehot(w_win_idx);
                w_last_nxt      = w_win_idx;
                w_dwell_nxt     = 8'd0;
                w_frame_buf_nxt = w_win_idx ? frame1 : frame0;
                w_gnt_nxt       = own_onehot(w_win_idx);
            end else begin
                w_owner_nxt = OWN_NONE;
                if (BLANK_IDLE) begin
                    w_frame_buf_nxt = '0;
                end
            end
        end
    end

    // ---- datapath registers ------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner_idx <= 1'b0;
            r_owner     <= OWN_NONE;
            r_last      <= 1'b1;        // requester 0 wins the first contest
            r_dwell     <= 8'd0;
            r_frame_buf <= '0;
            r_gnt       <= 2'b00;
        end else begin
            r_owner_idx <= w_owner_idx_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_dwell     <= w_dwell_nxt;
            r_frame_buf <= w_frame_buf_nxt;
            r_gnt       <= w_gnt_nxt;
        end
    end

    assign gnt   = r_gnt;
    assign owner = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_lattice_scan_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lattice_scan_arbiter
//  Description : Self-checking bench for lattice_scan_arbiter. A frame-level
//                reference model predicts row/col/owner/gnt/frame_done each
//                clk; directed phases plus randomized ticks, requests,
//                frames and resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lattice_scan_arbiter;

    localparam int DWELL      = 4;
    localparam bit BLANK_IDLE = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_tick;
    logic [1:0]  req;
    logic [63:0] frame0;
    logic [63:0] frame1;
    logic [1:0]  gnt;
    logic [1:0]  owner;
    logic        frame_done;
    logic [7:0]  row;
    logic [7:0]  col;

    lattice_scan_arbiter #(
        .DWELL      (DWELL),
        .BLANK_IDLE (BLANK_IDLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_tick  (scan_tick),
        .req        (req),
        .frame0     (frame0),
        .frame1     (frame1),
        .gnt        (gnt),
        .owner      (owner),
        .frame_done (frame_done),
        .row        (row),
        .col        (col)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state: current row index, displayed frame, owner
    // (-1 = none), last winner, frames shown so far in this ownership.
    int          m_idx;
    int          m_owner;
    int          m_last;
    int          m_dwell;
    logic [63:0] m_buf;
    logic [7:0]  m_row;
    logic [7:0]  m_col;
    logic [1:0]  m_gnt;
    logic        m_fd;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_frame_boundary();
        int win;
        if (m_owner >= 0 && req[m_owner] && m_dwell < DWELL - 1) begin
            m_dwell++;
            m_buf = (m_owner == 0) ? frame0 : frame1;
        end else begin
            win = -1;
            for (int k = 1; k <= 2; k++) begin
                if (win < 0 && req[(m_last + k) % 2]) win = (m_last + k) % 2;
            end
            if (win >= 0) begin
                m_owner = win;
                m_last  = win;
                m_dwell = 0;
                m_buf   = (win == 0) ? frame0 : frame1;
                m_gnt   = 2'b01 << win;
            end else begin
                m_owner = -1;
                if (BLANK_IDLE) m_buf = 64'd0;
            end
        end
    endtask

    task automatic model_step();
        logic [7:0] onehot;
        if (rst) begin
            m_idx = 0; m_owner = -1; m_last = 1; m_dwell = 0; m_buf = 64'd0;
            m_row = 8'hFF; m_col = 8'h00; m_gnt = 2'b00; m_fd = 1'b0;
        end else begin
            m_gnt = 2'b00;
            m_fd  = 1'b0;
            if (scan_tick) begin
                onehot = 8'd1 << m_idx;
                m_row  = ~onehot;
                m_col  = 8'(m_buf >> (8 * m_idx));
                if (m_idx == 7) begin
                    m_fd = 1'b1;
                    model_frame_boundary();
                end
                m_idx = (m_idx + 1) % 8;
            end
        end
    endtask

    // One clk: drive tick, let the edge happen, compare against the model.
    task automatic cyc(input bit tick);
        logic [1:0] own_exp;
        scan_tick = tick;
        @(posedge clk);
        #1;
        model_step();
        own_exp = (m_owner < 0) ? 2'b00 : (2'b01 << m_owner);
        check_val("row", row, m_row);
        check_val("col", col, m_col);
        check_val("owner", owner, own_exp);
        check_val("gnt", gnt, m_gnt);
        check_val("frame_done", frame_done, m_fd);
        @(negedge clk);
    endtask

    // Tick until the model reaches row index idx (and owner own, unless -2).
    task automatic tick_until(input int idx, input int own, input int limit);
        int n = 0;
        while (!(m_idx == idx && (own == -2 || m_owner == own)) && n < limit) begin
            cyc(1);
            n++;
        end
        check_val("reach_timeout", (n >= limit), 1'b0);
    endtask

    initial begin
        rst = 1'b1; scan_tick = 1'b0; req = 2'b00;
        frame0 = 64'd0; frame1 = 64'd0;
        m_idx = 0; m_owner = -1; m_last = 1; m_dwell = 0; m_buf = 64'd0;
        m_row = 8'hFF; m_col = 8'h00; m_gnt = 2'b00; m_fd = 1'b0;
        @(negedge clk);

        // Reset with ticks running: ticks must be ignored.
        repeat (3) cyc(1);
        rst = 1'b0;

        // Single requester, diagonal pattern.
        req    = 2'b01;
        frame0 = 64'h0102040810204080;
        frame1 = 64'hA5A5_5A5A_F0F0_0F0F;
        repeat (40) cyc(1);

        // Contended, random tick spacing, dwell rotation.
        req    = 2'b11;
        frame1 = {$urandom, $urandom};
        repeat (8 * 12 * 2) cyc(1'($urandom_range(0, 1)));

        // Mid-frame frame change must not tear.
        req = 2'b01;
        repeat (40) cyc(1);
        tick_until(3, -2, 16);
        frame0 = ~frame0;
        repeat (20) cyc(1);

        // Owner 0 drops at row 5 with no contender -> blank next frame.
        tick_until(5, 0, 80);
        req = 2'b00;
        repeat (20) cyc(1);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) req = 2'($urandom);
            if ($urandom_range(0, 29) == 0) frame0 = {$urandom, $urandom};
            if ($urandom_range(0, 29) == 0) frame1 = {$urandom, $urandom};
            rst = ($urandom_range(0, 299) == 0);
            cyc(1'($urandom_range(0, 3) != 0));
        end
        rst = 1'b0;

        // Reset at row 5 while requester 1 owns, then requester 0 wins first.
        req = 2'b11;
        tick_until(5, 1, 400);
        rst = 1'b1;
        cyc(1);
        check_val("rst_row", row, 8'hFF);
        check_val("rst_owner", owner, 2'b00);
        rst = 1'b0;
        begin
            int n = 0;
            while (gnt == 2'b00 && n < 20) begin
                cyc(1);
                n++;
            end
            check_val("regrant_timeout", (n >= 20), 1'b0);
            check_val("first_gnt_after_rst", gnt, 2'b01);
        end
        repeat (16) cyc(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
